// File: rtl/reg_operand_fetch_if.sv
// Decode-to-execute operand fetch bundle: instruction in, register file
// read port, writeback retire, and the buffered operand output.
interface reg_operand_fetch_if #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_sa;
   logic [AW-1:0] in_sb;
   logic [AW-1:0] in_da;
   logic          in_wr;
   logic [AW-1:0] rf_sa;
   logic [AW-1:0] rf_sb;
   logic [DW-1:0] rf_a;
   logic [DW-1:0] rf_b;
   logic          wb_valid;
   logic [AW-1:0] wb_da;
   logic [DW-1:0] wb_d;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic [AW-1:0] out_da;
   logic          out_wr;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  in_valid, in_sa, in_sb, in_da, in_wr,
      input  rf_a, rf_b,
      input  wb_valid, wb_da, wb_d,
      input  out_ready,
      output in_ready, rf_sa, rf_sb,
      output out_valid, out_a, out_b, out_da, out_wr,
      output stall_cnt
   );

   modport master (
      output in_valid, in_sa, in_sb, in_da, in_wr,
      output rf_a, rf_b,
      output wb_valid, wb_da, wb_d,
      output out_ready,
      input  in_ready, rf_sa, rf_sb,
      input  out_valid, out_a, out_b, out_da, out_wr,
      input  stall_cnt
   );
endinterface

// File: rtl/reg_operand_fetch.sv
// Operand fetch with a pending-write scoreboard and a one-entry output buffer.
// Define REG_OPERAND_FETCH_FORWARD_EN to bypass same-cycle writeback data.
module reg_operand_fetch #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input logic clk,
   input logic rst,
   reg_operand_fetch_if.slave bus
);
   localparam int NR = 2 ** AW;
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic {
      S_EMPTY,
      S_FULL
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [NR-1:0]    r_pend;
   logic [NR-1:0]    w_pend_nxt;
   logic [NR-1:0]    w_set;
   logic [NR-1:0]    w_clr;
   logic [DW-1:0]    r_a;
   logic [DW-1:0]    r_b;
   logic [AW-1:0]    r_da;
   logic             r_wr;
   logic [CNT_W-1:0] r_cnt;

   logic          w_fwd_a;
   logic          w_fwd_b;
   logic          w_fwd_d;
   logic          w_haz_a;
   logic          w_haz_b;
   logic          w_haz_d;
   logic          w_hazard;
   logic          w_room;
   logic          w_ready;
   logic          w_accept;
   logic          w_cnt_inc;
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;

`ifdef REG_OPERAND_FETCH_FORWARD_EN
   always_comb begin
      w_fwd_a = bus.wb_valid && (bus.wb_da == bus.in_sa) && (bus.in_sa != ZR);
      w_fwd_b = bus.wb_valid && (bus.wb_da == bus.in_sb) && (bus.in_sb != ZR);
      w_fwd_d = bus.wb_valid && (bus.wb_da == bus.in_da) && (bus.in_da != ZR);
   end
`else
   logic w_unused_wbd;
   assign w_unused_wbd = ^bus.wb_d;
   always_comb begin
      w_fwd_a = 1'b0;
      w_fwd_b = 1'b0;
      w_fwd_d = 1'b0;
   end
`endif

   always_comb begin
      w_haz_a  = r_pend[bus.in_sa] && !w_fwd_a;
      w_haz_b  = r_pend[bus.in_sb] && !w_fwd_b;
      w_haz_d  = bus.in_wr && r_pend[bus.in_da] && !w_fwd_d;
      w_hazard = bus.in_valid && (w_haz_a || w_haz_b || w_haz_d);
      w_room   = (r_state == S_EMPTY) || bus.out_ready;
      w_ready  = w_room && !w_hazard;
      w_accept = bus.in_valid && w_ready;
      w_cnt_inc = w_hazard && w_room && (r_cnt != CMAX);
   end

   // Zero register reads as 0 regardless of what the file returns
   always_comb begin
      w_a = bus.rf_a;
      w_b = bus.rf_b;
      if (w_fwd_a) w_a = bus.wb_d;
      if (w_fwd_b) w_b = bus.wb_d;
      if (bus.in_sa == ZR) w_a = '0;
      if (bus.in_sb == ZR) w_b = '0;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (bus.out_ready && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // Clear then set, so an issue to the retiring index stays pending
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (bus.wb_valid) w_clr[bus.wb_da] = 1'b1;
      if (w_accept && bus.in_wr && (bus.in_da != ZR)) w_set[bus.in_da] = 1'b1;
      w_pend_nxt = (r_pend & ~w_clr) | w_set;
      w_pend_nxt[ZR] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_pend  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a  <= '0;
         r_b  <= '0;
         r_da <= '0;
         r_wr <= 1'b0;
      end else if (w_accept) begin
         r_a  <= w_a;
         r_b  <= w_b;
         r_da <= bus.in_da;
         r_wr <= bus.in_wr;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.rf_sa     = bus.in_sa;
   assign bus.rf_sb     = bus.in_sb;
   assign bus.out_valid = (r_state == S_FULL);
   assign bus.out_a     = r_a;
   assign bus.out_b     = r_b;
   assign bus.out_da    = r_da;
   assign bus.out_wr    = r_wr;
   assign bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: vector table, directed hazard/reset
// sequences and randomized traffic against a scoreboard-level model.
module tb_reg_operand_fetch;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;
   localparam int ZR = 31;
`ifdef REG_OPERAND_FETCH_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_operand_fetch_if #(.DW(DW), .AW(AW), .CNT_W(CW)) bus ();

   reg_operand_fetch #(
      .DW(DW), .AW(AW), .ZERO_REG(ZR), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DW-1:0] rf [32];
   assign bus.rf_a = rf[bus.rf_sa];
   assign bus.rf_b = rf[bus.rf_sb];

   int tests = 0;
   int fails = 0;

   bit          m_pend [32];
   bit          m_full;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [4:0]  m_da;
   bit          m_wr;
   int          m_stall;

   typedef struct {
      logic [4:0]  sa;
      logic [4:0]  sb;
      logic [4:0]  da;
      bit          wr;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit src_haz(int s);
      return (s != ZR) && m_pend[s] &&
             !(FWD && bus.wb_valid && (int'(bus.wb_da) == s));
   endfunction

   function automatic logic [31:0] opnd(int s);
      if (s == ZR) return 32'h0;
      if (FWD && bus.wb_valid && (int'(bus.wb_da) == s)) return bus.wb_d;
      return rf[s];
   endfunction

   task automatic model_clear();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_full  = 1'b0;
      m_stall = 0;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_sa     = '0;
      bus.in_sb     = '0;
      bus.in_da     = '0;
      bus.in_wr     = 1'b0;
      bus.out_ready = 1'b1;
      bus.wb_valid  = 1'b0;
      bus.wb_da     = '0;
      bus.wb_d      = '0;
   endtask

   task automatic issue(int sa, int sb, int da, bit wr);
      bus.in_valid = 1'b1;
      bus.in_sa    = 5'(sa);
      bus.in_sb    = 5'(sb);
      bus.in_da    = 5'(da);
      bus.in_wr    = wr;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock: check in_ready, advance the model, check outputs
   task automatic tick();
      bit haz, room, rdy, acc, wbv, ordy, iw;
      logic [31:0] na, nb, wbd;
      logic [4:0] wbda, ida;
      #1;
      haz = bus.in_valid && (src_haz(bus.in_sa) || src_haz(bus.in_sb) ||
            (bus.in_wr && src_haz(bus.in_da)));
      ordy = bus.out_ready;
      room = !m_full || ordy;
      rdy  = room && !haz;
      acc  = bus.in_valid && rdy;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      na   = opnd(bus.in_sa);
      nb   = opnd(bus.in_sb);
      ida  = bus.in_da;
      iw   = bus.in_wr;
      wbv  = bus.wb_valid;
      wbda = bus.wb_da;
      wbd  = bus.wb_d;
      @(posedge clk);
      #1;
      if (haz && room && m_stall < 65535) m_stall++;
      if (acc) begin
         m_full = 1'b1;
         m_a = na;
         m_b = nb;
         m_da = ida;
         m_wr = iw;
      end else if (ordy) begin
         m_full = 1'b0;
      end
      if (wbv) m_pend[wbda] = 1'b0;
      if (acc && iw && ida != 5'(ZR)) m_pend[ida] = 1'b1;
      if (wbv && wbda != 5'(ZR)) rf[wbda] = wbd;
      chk("out_valid", 32'(bus.out_valid), 32'(m_full));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      if (m_full) begin
         chk("out_a", bus.out_a, m_a);
         chk("out_b", bus.out_b, m_b);
         chk("out_da", 32'(bus.out_da), 32'(m_da));
         chk("out_wr", 32'(bus.out_wr), 32'(m_wr));
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      rf[3]  = 32'h11;
      rf[4]  = 32'h22;
      rf[31] = 32'hDEAD_BEEF;

      tbl[0] = '{sa: 3,  sb: 4,  da: 0,  wr: 0, ea: 32'h11, eb: 32'h22};
      tbl[1] = '{sa: 4,  sb: 3,  da: 1,  wr: 0, ea: 32'h22, eb: 32'h11};
      tbl[2] = '{sa: 31, sb: 3,  da: 31, wr: 1, ea: 32'h0,  eb: 32'h11};
      tbl[3] = '{sa: 31, sb: 31, da: 2,  wr: 0, ea: 32'h0,  eb: 32'h0};
      tbl[4] = '{sa: 0,  sb: 30, da: 9,  wr: 0, ea: rf[0],  eb: rf[30]};
      tbl[5] = '{sa: 3,  sb: 31, da: 10, wr: 0, ea: 32'h11, eb: 32'h0};

      do_reset();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_a", bus.out_a, 32'h0);
      chk("rst_out_b", bus.out_b, 32'h0);
      chk("rst_out_da", 32'(bus.out_da), 32'h0);
      chk("rst_out_wr", 32'(bus.out_wr), 32'h0);
      chk("rst_stall", 32'(bus.stall_cnt), 32'h0);

      foreach (tbl[i]) begin
         issue(tbl[i].sa, tbl[i].sb, tbl[i].da, tbl[i].wr);
         #1;
         chk("tbl_ready", 32'(bus.in_ready), 32'h1);
         chk("tbl_rf_sa", 32'(bus.rf_sa), 32'(tbl[i].sa));
         tick();
         chk("tbl_a", bus.out_a, tbl[i].ea);
         chk("tbl_b", bus.out_b, tbl[i].eb);
         chk("tbl_da", 32'(bus.out_da), 32'(tbl[i].da));
      end

      // Issue writer of R5, then a dependent reader stalls until retire
      do_reset();
      issue(3, 4, 5, 1);
      tick();
      chk("t1_valid", 32'(bus.out_valid), 32'h1);
      chk("t1_a", bus.out_a, 32'h11);
      chk("t1_b", bus.out_b, 32'h22);
      issue(5, 4, 6, 0);
      repeat (3) tick();
      chk("t2_stalled", 32'(bus.in_ready), 32'h0);
      bus.wb_valid = 1'b1;
      bus.wb_da    = 5'd5;
      bus.wb_d     = 32'hAB;
      #1;
      chk("t2_wb_ready", 32'(bus.in_ready), 32'(FWD));
      tick();
      bus.wb_valid = 1'b0;
      tick();
      chk("t2_a", bus.out_a, 32'hAB);
      chk("t2_stall", 32'(bus.stall_cnt), FWD ? 32'd3 : 32'd4);

      // Backpressure with no hazard: held, not counted
      bus.out_ready = 1'b0;
      issue(1, 2, 8, 0);
      repeat (4) tick();
      chk("t4_hold_a", bus.out_a, 32'hAB);
      chk("t4_stall", 32'(bus.stall_cnt), FWD ? 32'd3 : 32'd4);
      bus.out_ready = 1'b1;
      #1;
      chk("t4_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("t4_new_a", bus.out_a, 32'h1000_0111);
      chk("t4_new_b", bus.out_b, 32'h1000_0222);

      // Asynchronous reset mid-stall with a full buffer and R7 pending
      do_reset();
      issue(1, 2, 7, 1);
      tick();
      issue(7, 2, 12, 0);
      tick();
      issue(1, 2, 13, 0);
      tick();
      bus.out_ready = 1'b0;
      issue(7, 2, 12, 0);
      tick();
      chk("t6_pre_valid", 32'(bus.out_valid), 32'h1);
      chk("t6_pre_stall", 32'(bus.stall_cnt), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid", 32'(bus.out_valid), 32'h0);
      chk("t6_stall", 32'(bus.stall_cnt), 32'h0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      issue(7, 7, 11, 0);
      #1;
      chk("t6_pend_clr", 32'(bus.in_ready), 32'h1);
      tick();

      for (int n = 0; n < 3000; n++) begin
         int r;
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 8);
         bus.in_sa     = (r == 8) ? 5'd31 : 5'(r);
         r = $urandom_range(0, 8);
         bus.in_sb     = (r == 8) ? 5'd31 : 5'(r);
         r = $urandom_range(0, 8);
         bus.in_da     = (r == 8) ? 5'd31 : 5'(r);
         bus.in_wr     = $urandom_range(0, 1) == 1;
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.wb_valid  = ($urandom_range(0, 9) < 3);
         r = $urandom_range(0, 8);
         bus.wb_da     = (r == 8) ? 5'd31 : 5'(r);
         bus.wb_d      = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
